// File: rtl/fb_scanout.sv
// VGA-timed framebuffer scanout: walks the raster, issues one read address per
// visible pixel and delays timing/coordinates to line up with the read data.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [18:0] fb_raddr,
  input  logic [23:0] fb_rdata,
  output logic [23:0] pixel,
  output logic [9:0]  counterX,
  output logic [9:0]  counterY,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        running
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  h;
  logic [9:0]  v;
  logic        h_end;
  logic        frame_end;
  logic        act;
  logic        hs_n;
  logic        vs_n;

  logic [RD_LAT-1:0]       act_p;
  logic [RD_LAT-1:0]       hs_p;
  logic [RD_LAT-1:0]       vs_p;
  logic [RD_LAT-1:0][9:0]  h_p;
  logic [RD_LAT-1:0][9:0]  v_p;

  assign h_end     = (h == H_LAST);
  assign frame_end = h_end && (v == V_LAST);
  assign running   = (state != IDLE);

  assign act  = running && (h < H_ACT) && (v < V_ACT);
  assign hs_n = !((h >= HS_BEG) && (h < HS_END));
  assign vs_n = !((v >= VS_BEG) && (v < VS_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A stop request only takes effect at the last pixel of a frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (enable) state_next = RUN;
      RUN:      if (!enable) state_next = STOPPING;
      STOPPING: begin
        if (enable)         state_next = RUN;
        else if (frame_end) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (state == IDLE) begin
      h <= '0;
      v <= '0;
    end else if (h_end) begin
      h <= '0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Address tracks v*H_ACTIVE+h by counting visible pixels instead of multiplying.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_raddr <= '0;
    end else if (state != IDLE) begin
      if (frame_end) fb_raddr <= '0;
      else if (act)  fb_raddr <= fb_raddr + 19'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_p <= '0;
      hs_p  <= '1;
      vs_p  <= '1;
      h_p   <= '0;
      v_p   <= '0;
    end else begin
      act_p[0] <= act;
      hs_p[0]  <= hs_n;
      vs_p[0]  <= vs_n;
      h_p[0]   <= h;
      v_p[0]   <= v;
      for (int i = 1; i < RD_LAT; i++) begin
        act_p[i] <= act_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        h_p[i]   <= h_p[i-1];
        v_p[i]   <= v_p[i-1];
      end
    end
  end

  // Output stage captures the read data together with its delayed timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel       <= '0;
      counterX    <= '0;
      counterY    <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pixel       <= act_p[RD_LAT-1] ? fb_rdata : 24'd0;
      counterX    <= h_p[RD_LAT-1];
      counterY    <= v_p[RD_LAT-1];
      de          <= act_p[RD_LAT-1];
      hsync       <= hs_p[RD_LAT-1];
      vsync       <= vs_p[RD_LAT-1];
      frame_start <= act_p[RD_LAT-1] && (h_p[RD_LAT-1] == 10'd0) && (v_p[RD_LAT-1] == 10'd0);
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a full-size instance (RD_LAT=1) and a shrunken-timing
// instance (RD_LAT=3) driven by scripted and random enable, checked against a raster model.
`timescale 1ns/1ps
module tb_fb_scanout;

  typedef struct {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int lat;
  } timing_t;

  typedef struct {
    bit act; bit hs; bit vs;
    int h; int v; int addr;
  } stage_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  logic [18:0] ra_a, ra_b;
  logic [23:0] rd_a, rd_b, pix_a, pix_b;
  logic [9:0]  cx_a, cy_a, cx_b, cy_b;
  logic        de_a, hs_a, vs_a, fs_a, run_a;
  logic        de_b, hs_b, vs_b, fs_b, run_b;

  fb_scanout dut_a (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_raddr(ra_a), .fb_rdata(rd_a), .pixel(pix_a),
    .counterX(cx_a), .counterY(cy_a), .de(de_a),
    .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a), .running(run_a)
  );

  fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .RD_LAT(3)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_raddr(ra_b), .fb_rdata(rd_b), .pixel(pix_b),
    .counterX(cx_b), .counterY(cy_b), .de(de_b),
    .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b), .running(run_b)
  );

  // Memory models: data = address, except the out-of-frame address reads all ones.
  logic [18:0] mq_a [3] = '{default: '0};
  logic [18:0] mq_b [3] = '{default: '0};

  function automatic logic [23:0] memData(input logic [18:0] a, input int limit);
    return (int'(a) >= limit) ? 24'hFFFFFF : {5'b0, a};
  endfunction

  always @(posedge clk) begin
    mq_a[0] <= ra_a; mq_a[1] <= mq_a[0]; mq_a[2] <= mq_a[1];
    mq_b[0] <= ra_b; mq_b[1] <= mq_b[0]; mq_b[2] <= mq_b[1];
  end

  assign rd_a = memData(mq_a[0], 640 * 480);
  assign rd_b = memData(mq_b[2], 16 * 12);

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  timing_t tp [2];
  bit      m_active [2];
  bit      m_stop [2];
  int      m_t [2];
  stage_t  hist [2][4];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Raster position t counts pixels from the top-left of the frame.
  function automatic stage_t stageAt(input timing_t p, input bit active, input int t);
    stage_t s;
    int htot;
    htot = p.ha + p.hfp + p.hs + p.hbp;
    s.act = 1'b0; s.hs = 1'b1; s.vs = 1'b1; s.h = 0; s.v = 0; s.addr = 0;
    if (active) begin
      s.h   = t % htot;
      s.v   = t / htot;
      s.act = (s.h < p.ha) && (s.v < p.va);
      s.hs  = !((s.h >= p.ha + p.hfp) && (s.h < p.ha + p.hfp + p.hs));
      s.vs  = !((s.v >= p.va + p.vfp) && (s.v < p.va + p.vfp + p.vs));
      if (s.v >= p.va)      s.addr = p.ha * p.va;
      else if (s.h >= p.ha) s.addr = (s.v + 1) * p.ha;
      else                  s.addr = s.v * p.ha + s.h;
    end
    return s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_stop[i]   = 1'b0;
      m_t[i]      = 0;
      for (int k = 0; k < 4; k++) hist[i][k] = stageAt(tp[i], 1'b0, 0);
    end
  endtask

  task automatic stepAndCheck();
    stage_t e, s0;
    logic [23:0] pix;
    logic [9:0]  cx, cy;
    logic [3:0]  flags;
    logic [18:0] ra;
    logic        run;
    int          ftot;
    string       who;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        pix = pix_a; cx = cx_a; cy = cy_a; flags = {de_a, hs_a, vs_a, fs_a}; ra = ra_a; run = run_a;
      end else begin
        pix = pix_b; cx = cx_b; cy = cy_b; flags = {de_b, hs_b, vs_b, fs_b}; ra = ra_b; run = run_b;
      end
      who = $sformatf("%s cyc %0d", (i == 0) ? "A" : "B", cycle);
      e = hist[i][tp[i].lat];
      checkOutput({"pixel ", who}, 32'(pix), e.act ? (e.addr & 32'hFFFFFF) : 32'd0);
      checkOutput({"counter ", who}, {12'd0, cx, cy}, 32'(e.h * 1024 + e.v));
      checkOutput({"de/hs/vs/fs ", who}, 32'(flags),
                  32'({e.act, e.hs, e.vs, e.act && e.h == 0 && e.v == 0}));
      s0 = stageAt(tp[i], m_active[i], m_t[i]);
      checkOutput({"raddr ", who}, 32'(ra), 32'(s0.addr));
      checkOutput({"running ", who}, 32'(run), 32'(m_active[i]));
      for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = s0;
      ftot = (tp[i].ha + tp[i].hfp + tp[i].hs + tp[i].hbp) * (tp[i].va + tp[i].vfp + tp[i].vs + tp[i].vbp);
      if (rst) begin
        m_active[i] = 1'b0; m_stop[i] = 1'b0; m_t[i] = 0;
      end else if (!m_active[i]) begin
        if (enable) begin m_active[i] = 1'b1; m_stop[i] = 1'b0; m_t[i] = 0; end
      end else if (m_stop[i] && !enable && m_t[i] == ftot - 1) begin
        m_active[i] = 1'b0; m_t[i] = 0;
      end else begin
        m_t[i]    = (m_t[i] == ftot - 1) ? 0 : m_t[i] + 1;
        m_stop[i] = !enable;
      end
    end
    cycle++;
  endtask

  task automatic applyStimulus(input bit en, input int n);
    repeat (n) begin
      enable = en;
      stepAndCheck();
      @(negedge clk);
    end
  endtask

  task automatic midCycleReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst pixel A", 32'(pix_a), 32'd0);
    checkOutput("async rst flags A", 32'({de_a, hs_a, vs_a, fs_a}), 32'b0110);
    checkOutput("async rst raddr B", 32'(ra_b), 32'd0);
    checkOutput("async rst counter B", {12'd0, cx_b, cy_b}, 32'd0);
    checkOutput("async rst flags B", 32'({de_b, hs_b, vs_b, fs_b, run_b}), 32'b01100);
    modelReset();
    @(negedge clk);
    applyStimulus(1'b1, 3);
    rst = 1'b0;
  endtask

  int seg_val [5] = '{1, 0, 1, 0, 1};
  int seg_len [5] = '{600, 100, 50, 1200, 1000};

  initial begin
    tp[0] = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33, lat: 1};
    tp[1] = '{ha: 16,  hfp: 2,  hs: 4,  hbp: 3,  va: 12,  vfp: 2,  vs: 2, vbp: 3,  lat: 3};
    modelReset();
    @(negedge clk);
    applyStimulus(1'b0, 3);
    rst = 1'b0;
    applyStimulus(1'b0, 3);
    for (int s = 0; s < 5; s++) applyStimulus(seg_val[s][0], seg_len[s]);
    for (int s = 0; s < 6; s++) applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 700)));
    applyStimulus(1'b1, 137);
    midCycleReset();
    applyStimulus(1'b1, 1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
